// File: rtl/operand_sequencer.sv
// operand_sequencer: latches four operands on start and sends them one at a time on a shared bus.
// Optional abort-on-handshake-loss behaviour is enabled by defining OPSEQ_ABORT_EN.
module operand_sequencer #(
  parameter int          WIDTH       = 8,
  parameter int          HOLD_CYCLES = 1,
  parameter logic [2:0]  READ_CODE   = 3'b001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] dx_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] u_in,
  input  logic [2:0]       ctrl_state,
  output logic [WIDTH-1:0] data_out,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic             s4,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_READ = 3'd1,
    SEND_X    = 3'd2,
    SEND_DX   = 3'd3,
    SEND_A    = 3'd4,
    SEND_U    = 3'd5,
    READY     = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t           state_r, next_state_s;
  logic [3:0]       hold_cnt_r;
  logic [WIDTH-1:0] x_r, dx_r, a_r, u_r;
  logic [WIDTH-1:0] data_s, data_r;
  logic [3:0]       strobe_s, strobe_r;
  logic             ready_r, busy_r, done_r, err_r;
  logic             is_send_s, next_is_send_s, read_s, abort_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and Moore decode of the upcoming state into output values
  always_comb begin
    next_state_s   = state_r;
    is_send_s      = 1'b0;
    next_is_send_s = 1'b0;
    read_s         = (ctrl_state == READ_CODE);
    abort_s        = 1'b0;
    data_s         = '0;
    strobe_s       = 4'b0000;

    is_send_s = (state_r == SEND_X) || (state_r == SEND_DX) ||
                (state_r == SEND_A) || (state_r == SEND_U);
`ifdef OPSEQ_ABORT_EN
    abort_s = is_send_s && !read_s;
`else
    abort_s = 1'b0;
`endif

    case (state_r)
      IDLE:      if (start) next_state_s = WAIT_READ; else next_state_s = IDLE;
      WAIT_READ: if (read_s) next_state_s = SEND_X; else next_state_s = WAIT_READ;
      SEND_X:    if (hold_cnt_r == 4'd0) next_state_s = SEND_DX; else next_state_s = SEND_X;
      SEND_DX:   if (hold_cnt_r == 4'd0) next_state_s = SEND_A; else next_state_s = SEND_DX;
      SEND_A:    if (hold_cnt_r == 4'd0) next_state_s = SEND_U; else next_state_s = SEND_A;
      SEND_U:    if (hold_cnt_r == 4'd0) next_state_s = READY; else next_state_s = SEND_U;
      READY:     if (!read_s) next_state_s = DONE; else next_state_s = READY;
      DONE:      next_state_s = IDLE;
      default:   next_state_s = IDLE;
    endcase

    if (abort_s) begin
      next_state_s = IDLE;
    end else begin
      next_state_s = next_state_s;
    end

    next_is_send_s = (next_state_s == SEND_X) || (next_state_s == SEND_DX) ||
                     (next_state_s == SEND_A) || (next_state_s == SEND_U);

    // Operands were latched on the IDLE exit edge, so they are valid before any SEND state
    case (next_state_s)
      SEND_X:  begin data_s = x_r;  strobe_s = 4'b0001; end
      SEND_DX: begin data_s = dx_r; strobe_s = 4'b0010; end
      SEND_A:  begin data_s = a_r;  strobe_s = 4'b0100; end
      SEND_U:  begin data_s = u_r;  strobe_s = 4'b1000; end
      default: begin data_s = '0;   strobe_s = 4'b0000; end
    endcase
  end

  // Hold counter: reload on entry to each SEND state, count down while sending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_r <= 4'd0;
    end else if (next_is_send_s && (next_state_s != state_r)) begin
      hold_cnt_r <= HOLD_LOAD;
    end else if (is_send_s && (hold_cnt_r != 4'd0)) begin
      hold_cnt_r <= hold_cnt_r - 4'd1;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Operand capture, only on an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r  <= '0;
      dx_r <= '0;
      a_r  <= '0;
      u_r  <= '0;
    end else if ((state_r == IDLE) && start) begin
      x_r  <= x_in;
      dx_r <= dx_in;
      a_r  <= a_in;
      u_r  <= u_in;
    end else begin
      x_r  <= x_r;
      dx_r <= dx_r;
      a_r  <= a_r;
      u_r  <= u_r;
    end
  end

  // Output registers, aligned with the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r   <= '0;
      strobe_r <= 4'b0000;
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      data_r   <= data_s;
      strobe_r <= strobe_s;
      ready_r  <= (next_state_s == READY);
      busy_r   <= (next_state_s != IDLE);
      done_r   <= (next_state_s == DONE);
      err_r    <= abort_s;
    end
  end

  assign data_out = data_r;
  assign s1       = strobe_r[0];
  assign s2       = strobe_r[1];
  assign s3       = strobe_r[2];
  assign s4       = strobe_r[3];
  assign ready    = ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed self-checking bench for operand_sequencer; HOLD_CYCLES=1 and HOLD_CYCLES=3 instances.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x_in, dx_in, a_in, u_in;
  logic [2:0] ctrl_state;

  logic [7:0] d1_data, d3_data;
  logic       d1_s1, d1_s2, d1_s3, d1_s4, d1_ready, d1_busy, d1_done, d1_err;
  logic       d3_s1, d3_s2, d3_s3, d3_s4, d3_ready, d3_busy, d3_done, d3_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  operand_sequencer #(.WIDTH(8), .HOLD_CYCLES(1), .READ_CODE(3'b001)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .x_in(x_in), .dx_in(dx_in), .a_in(a_in), .u_in(u_in), .ctrl_state(ctrl_state),
    .data_out(d1_data), .s1(d1_s1), .s2(d1_s2), .s3(d1_s3), .s4(d1_s4),
    .ready(d1_ready), .busy(d1_busy), .done(d1_done), .err(d1_err)
  );

  operand_sequencer #(.WIDTH(8), .HOLD_CYCLES(3), .READ_CODE(3'b001)) dut3 (
    .clk(clk), .reset(reset), .start(start),
    .x_in(x_in), .dx_in(dx_in), .a_in(a_in), .u_in(u_in), .ctrl_state(ctrl_state),
    .data_out(d3_data), .s1(d3_s1), .s2(d3_s2), .s3(d3_s3), .s4(d3_s4),
    .ready(d3_ready), .busy(d3_busy), .done(d3_done), .err(d3_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // View of dut1: {data, s4..s1, ready, busy, done, err}
  function automatic logic [31:0] view1();
    return {16'd0, d1_data, d1_s4, d1_s3, d1_s2, d1_s1, d1_ready, d1_busy, d1_done, d1_err};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_ops(input logic [7:0] x, input logic [7:0] dx, input logic [7:0] a, input logic [7:0] u);
    x_in = x; dx_in = dx; a_in = a; u_in = u;
  endtask

  initial begin
    logic [3:0] exp_strobe;
    logic [7:0] exp_data;
    reset = 1'b1; start = 1'b0; ctrl_state = 3'b001;
    set_ops(8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    check_eq("reset_idle", view1(), 32'h0);
    reset = 1'b0;
    tick();

    // Reset asserted while in SEND_DX
    set_ops(8'h11, 8'h22, 8'h33, 8'h44);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check_eq("pre_reset_dx", view1(), {16'd0, 8'h22, 4'b0010, 4'b0100});
    #2 reset = 1'b1;
    #1 check_eq("async_reset_outputs", view1(), 32'h0);
    tick(); reset = 1'b0;
    tick(); tick(); tick();
    check_eq("stay_idle", view1(), 32'h0);

    // Nominal transfer, HOLD=1
    start = 1'b1; tick(); start = 1'b0;
    check_eq("k1_wait_read", view1(), {16'd0, 8'h00, 4'b0000, 4'b0100});
    tick(); check_eq("k2_s1", view1(), {16'd0, 8'h11, 4'b0001, 4'b0100});
    tick(); check_eq("k3_s2", view1(), {16'd0, 8'h22, 4'b0010, 4'b0100});
    tick(); check_eq("k4_s3", view1(), {16'd0, 8'h33, 4'b0100, 4'b0100});
    tick(); check_eq("k5_s4", view1(), {16'd0, 8'h44, 4'b1000, 4'b0100});
    tick(); check_eq("k6_ready", view1(), {16'd0, 8'h00, 4'b0000, 4'b1100});
    tick(); check_eq("k7_ready_held", view1(), {16'd0, 8'h00, 4'b0000, 4'b1100});
    do_reset();

    // Wait for READ, then handshake out of READY
    ctrl_state = 3'b000;
    set_ops(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("wait_no_strobe", view1(), {16'd0, 8'h00, 4'b0000, 4'b0100});
    end
    ctrl_state = 3'b001;
    tick(); check_eq("wait_s1", view1(), {16'd0, 8'hA1, 4'b0001, 4'b0100});
    tick(); tick(); tick(); tick();
    check_eq("hs_ready", view1(), {16'd0, 8'h00, 4'b0000, 4'b1100});
    ctrl_state = 3'b010;
    tick(); check_eq("hs_done", view1(), {16'd0, 8'h00, 4'b0000, 4'b0110});
    tick(); check_eq("hs_idle", view1(), 32'h0);
    ctrl_state = 3'b001;
    do_reset();

    // HOLD=3 on dut3, x_in changed mid-transfer
    set_ops(8'h11, 8'h22, 8'h33, 8'h44);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("h3_wait", {31'd0, d3_busy}, 32'd1);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 1) x_in = 8'hFF;
      case (c / 3)
        0: begin exp_strobe = 4'b0001; exp_data = 8'h11; end
        1: begin exp_strobe = 4'b0010; exp_data = 8'h22; end
        2: begin exp_strobe = 4'b0100; exp_data = 8'h33; end
        default: begin exp_strobe = 4'b1000; exp_data = 8'h44; end
      endcase
      check_eq("h3_strobe", {28'd0, d3_s4, d3_s3, d3_s2, d3_s1}, {28'd0, exp_strobe});
      check_eq("h3_data", {24'd0, d3_data}, {24'd0, exp_data});
    end
    tick(); check_eq("h3_ready", {30'd0, d3_ready, d3_busy}, 32'd3);
    do_reset();

    // start during SEND_A is ignored
    set_ops(8'h51, 8'h52, 8'h53, 8'h54);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check_eq("busy_s3", view1(), {16'd0, 8'h53, 4'b0100, 4'b0100});
    start = 1'b1;
    set_ops(8'hE1, 8'hE2, 8'hE3, 8'hE4);
    tick(); start = 1'b0;
    check_eq("busy_s4_orig", view1(), {16'd0, 8'h54, 4'b1000, 4'b0100});
    tick(); check_eq("busy_ready", view1(), {16'd0, 8'h00, 4'b0000, 4'b1100});
    tick(); check_eq("busy_no_restart", view1(), {16'd0, 8'h00, 4'b0000, 4'b1100});
    do_reset();

    // Handshake lost during SEND_DX
    set_ops(8'h61, 8'h62, 8'h63, 8'h64);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check_eq("ab_dx", view1(), {16'd0, 8'h62, 4'b0010, 4'b0100});
    ctrl_state = 3'b000;
    tick();
`ifdef OPSEQ_ABORT_EN
    check_eq("ab_err", view1(), {16'd0, 8'h00, 4'b0000, 4'b0001});
    tick(); check_eq("ab_idle", view1(), 32'h0);
    tick(); check_eq("ab_no_done", view1(), 32'h0);
`else
    check_eq("na_s3", view1(), {16'd0, 8'h63, 4'b0100, 4'b0100});
    tick(); check_eq("na_s4", view1(), {16'd0, 8'h64, 4'b1000, 4'b0100});
    tick(); check_eq("na_ready", view1(), {16'd0, 8'h00, 4'b0000, 4'b1100});
    tick(); check_eq("na_done", view1(), {16'd0, 8'h00, 4'b0000, 4'b0110});
    tick(); check_eq("na_idle", view1(), 32'h0);
`endif
    ctrl_state = 3'b001;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Transmitter side of the differentiator operand-load protocol. On `start` it latches the four operands (x, dx, a, u) and drives them one at a time onto a shared data bus. Each operand is qualified by its one-hot select strobe (`s1`..`s4`). After the last operand it raises `ready` and holds it until the solver controller leaves its READ state. The block sits between the testbench/host and the controller, and handshakes against the controller's 3-bit `state` output.

## Interface
- `WIDTH`, default 8: operand and data-bus width in bits.
- `HOLD_CYCLES`, default 1: cycles each strobe/operand is held; legal range 1..15.
- `READ_CODE`, default 3'b001: controller state code meaning READ.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request a transfer; sampled only in IDLE.
- `x_in`, `dx_in`, `a_in`, `u_in` input WIDTH each: operands, latched on accepted `start`.
- `ctrl_state` input 3: controller current state.
- `data_out` output WIDTH: operand currently being sent; 0 when not sending.
- `s1`, `s2`, `s3`, `s4` output 1 each: one-hot strobes for x, dx, a, u.
- `ready` output 1: all operands sent.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the transfer completes.
- `err` output 1: one-cycle abort pulse (only with `OPSEQ_ABORT_EN`).

## Operation
- States: IDLE, WAIT_READ, SEND_X, SEND_DX, SEND_A, SEND_U, READY, DONE.
- IDLE: if `start`=1, latch the four operands, then go to WAIT_READ. Otherwise stay.
- WAIT_READ: go to SEND_X when `ctrl_state`==READ_CODE. Otherwise wait indefinitely.
- SEND_* states:
  - Load the hold counter with HOLD_CYCLES-1 on entry.
  - Decrement it each cycle.
  - Advance X→DX→A→U→READY when it reads 0.
- READY: `ready`=1. Go to DONE on the first cycle `ctrl_state`≠READ_CODE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Outputs are Moore-decoded from the registered state:
  - `s1`=1 only in SEND_X, with `data_out`=x. Likewise `s2`/dx, `s3`/a, `s4`/u.
  - At most one strobe is high in any cycle.
- Operand registers are frozen while `busy`; input changes mid-transfer have no effect.
- `start` outside IDLE is ignored. No queuing.
- `start` held high continuously produces back-to-back transfers; each new transfer begins from IDLE.

## Timing
- Reset, including mid-transfer, takes effect immediately:
  - State returns to IDLE.
  - Operand registers and hold counter clear to 0.
  - `data_out`, `s1..s4`, `ready`, `busy`, `done` and `err` all go to 0.
- Latency with HOLD_CYCLES=1 and `ctrl_state`=READ_CODE throughout, `start` sampled at edge k:
  - WAIT_READ in cycle k+1.
  - `s1` in k+2, `s2` in k+3, `s3` in k+4, `s4` in k+5.
  - `ready` from k+6 onward.
- General case: each strobe lasts exactly HOLD_CYCLES cycles, and strobes are contiguous with no gap.
- `ready` deasserts in the cycle after `ctrl_state`≠READ_CODE is sampled. `done` is high in that same cycle.
- Minimum IDLE-to-IDLE transfer: 4·HOLD_CYCLES+4 cycles.

## Configuration
- `OPSEQ_ABORT_EN` defined:
  - If `ctrl_state`≠READ_CODE is sampled in any SEND_* state, the next state is IDLE.
  - `err` pulses for one cycle in that next cycle.
  - The strobes drop, and `done` does not pulse.
- `OPSEQ_ABORT_EN` undefined:
  - `ctrl_state` is ignored during SEND_* states.
  - `err` is tied to 0.

## Test plan
- Reset then check idle outputs: assert `reset` mid-SEND_DX → in the same cycle all outputs are 0 and `busy`=0. After release, with no `start`, the block stays in IDLE.
- Nominal transfer: x=8'h11, dx=8'h22, a=8'h33, u=8'h44, HOLD=1, `ctrl_state`=3'b001 → `data_out` reads 11,22,33,44 on `s1`..`s4` in cycles k+2..k+5. `ready`=1 from k+6.
- Wait and handshake: hold `ctrl_state`=3'b000 for 5 cycles after `start` → no strobes and `busy`=1. Then set 3'b001 → `s1` on the next cycle. In READY, set `ctrl_state`=3'b010 → `ready`=0 and `done`=1 for one cycle, then `busy`=0.
- HOLD_CYCLES=3: each strobe is high exactly 3 cycles and only one strobe is ever high. Changing `x_in` to 8'hFF mid-transfer does not alter `data_out`.
- `start` while busy is ignored: a second `start` during SEND_A produces no restart. The operand registers keep their original values.
- Abort (`OPSEQ_ABORT_EN`): `ctrl_state`→3'b000 during SEND_DX → `err`=1 for one cycle, then IDLE with no `done`. Without the macro, the sequence completes normally.
